clock_ctrl: RTL and testbench
=============================

Name: clock_ctrl

Overview:
Top-level sequencer for the clock application. It debounces the user buttons and walks the set sequence hour → minute → second, taking each value from the switch input. It then runs a 24-hour time-of-day counter with pause and re-set. It drives the total-seconds bus and the per-field blink flags consumed by the display path.

Parameters:
CLK_HZ, 50000000, clk cycles per second (tick prescaler terminal = CLK_HZ-1)
HALF_SEC, 25000000, clk cycles per blink phase
DEBOUNCE, 500000, cycles a synchronized button level must be stable to be accepted

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-low reset
button  in  1  raw select/advance push button, active-low, asynchronous to clk
pause_btn  in  1  raw run/pause push button, active-low, asynchronous to clk
start_num  in  6  switch value for the field being set
c_out  out  17  hr*3600 + min*60 + sec, registered
blink_hr_sig  out  1  hour digits blank phase
blink_min_sig  out  1  minute digits blank phase
blink_sec_sig  out  1  second digits blank phase
running  out  1  high in RUN
tick  out  1  one-cycle pulse on each one-second increment
mode  out  3  current FSM state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst. All state and outputs update on posedge clk only.
- Reset values: state SET_HR; hr/min/sec = 0; c_out = 0; all blink outputs = 0; tick = 0; running = 0; prescaler = 0; blink counter = 0; debounce state = released (1).
- Input conditioning:
  - Each button passes through a 2-flop synchronizer.
  - The debouncer accepts a new level only after DEBOUNCE consecutive equal samples.
  - A press event is a one-cycle pulse when the accepted level goes 1→0. Releases generate no event.
  - Latency from a stable raw edge to the press pulse is DEBOUNCE+3 cycles.
- Field clamp: hr_in = min(start_num, 23); ms_in = min(start_num, 59).
- SET_HR: hr follows hr_in every cycle (live preview). A button press latches the value and moves to SET_MIN.
- SET_MIN: min follows ms_in. A button press moves to SET_SEC.
- SET_SEC: sec follows ms_in. A button press moves to RUN and clears the prescaler.
- RUN:
  - The prescaler counts 0..CLK_HZ-1. At terminal it wraps to 0, tick pulses for 1 cycle, and the time increments.
  - Increment carries: sec 59→0 carries to min, min 59→0 carries to hr, and 23:59:59 → 00:00:00.
  - A pause_btn press moves to PAUSE.
  - A button press moves to SET_HR, keeping the current min/sec; hr immediately follows hr_in.
- PAUSE: prescaler and time hold. A pause_btn press moves to RUN with the prescaler value retained. A button press moves to SET_HR.
- pause_btn presses in SET_* states are ignored.
- Simultaneous button and pause_btn presses in the same cycle: button wins and pause_btn is dropped.
- A tick and a button press in the same RUN cycle: the increment is applied, then the FSM goes to SET_HR and hr is overwritten by the preview from the next cycle.
- Blink (SET_* states only):
  - The counter runs 0..HALF_SEC-1; at terminal a phase bit toggles.
  - blink_x_sig = phase AND (state is SET_x).
  - Counter and phase clear to 0 on every state change, so each field starts visible.
  - In RUN and PAUSE all blink outputs are 0.
- c_out: registered from the current hr/min/sec, 1-cycle latency. Maximum value 86399 fits in 17 bits. Intermediate products are computed at ≥17 bits with no truncation.
- running = (state == RUN). mode encodings: SET_HR=0, SET_MIN=1, SET_SEC=2, RUN=3, PAUSE=4. Encodings 5-7 are illegal and recover to SET_HR on the next cycle.
- Reset asserted mid-operation: takes effect on the next clk edge, returns all of the above to reset values, and drops any pending debounce.

Decomposition:
- Shared package clock_pkg holds:
  - state encodings
  - MAX_HR=23, MAX_MS=59, DAY_LAST=86399
  - the 17-bit time width constant
- One sub-module, btn_debounce (synchronizer + stable counter + falling-edge pulse, parameter DEBOUNCE), instantiated twice.

Test Plan:
All scenarios use CLK_HZ=10, HALF_SEC=4, DEBOUNCE=3.
1. Reset, start_num=13, press button → c_out=46800 in SET_MIN. Set start_num=45, press → SET_SEC. Set start_num=7, press → RUN, c_out=49507, running=1.
2. start_num=40 in SET_HR → hr clamps to 23, c_out=82800. start_num=63 in SET_MIN → min=59.
3. Set 23:59:58, run 20 cycles → two tick pulses 10 cycles apart; c_out goes 86399 then 0.
4. In RUN, press pause_btn → mode=4, c_out frozen for 50 cycles. Press pause_btn again → next tick arrives after the remaining prescaler count, not a full 10 cycles.
5. In SET_MIN → blink_min_sig toggles every 4 cycles and the other blinks stay 0. Press button → blink_sec_sig low for 4 cycles, then high.
6. Press button and pause_btn in the same cycle during RUN → mode=0, not 4. A 2-cycle glitch on button → no press event. Reset mid-RUN → c_out=0, mode=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock application: FSM encodings, field limits
// and the conversion of hr/min/sec into a total-seconds value.
package clock_pkg;

  localparam int TIME_W   = 17;
  localparam int MAX_HR   = 23;
  localparam int MAX_MS   = 59;
  localparam int DAY_LAST = 86399;

  typedef enum logic [2:0] {
    SET_HR  = 3'd0,
    SET_MIN = 3'd1,
    SET_SEC = 3'd2,
    RUN     = 3'd3,
    PAUSE   = 3'd4
  } state_t;

  // Operands are widened to TIME_W first so no partial product is truncated.
  function automatic logic [TIME_W-1:0] to_seconds(input logic [4:0] h,
                                                   input logic [5:0] m,
                                                   input logic [5:0] s);
    logic [TIME_W-1:0] hh, mm, ss;
    hh = {12'd0, h};
    mm = {11'd0, m};
    ss = {11'd0, s};
    return hh * 17'd3600 + mm * 17'd60 + ss;
  endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// User-facing signal bundle of the clock controller: raw buttons and switch
// value in, time bus, blink flags and status out.
interface clock_ctrl_if;
  import clock_pkg::*;

  logic              button;
  logic              pause_btn;
  logic [5:0]        start_num;
  logic [TIME_W-1:0] c_out;
  logic              blink_hr_sig;
  logic              blink_min_sig;
  logic              blink_sec_sig;
  logic              running;
  logic              tick;
  logic [2:0]        mode;

  // Buttons are level inputs with no handshake; every output is a plain
  // registered level (tick is a single-cycle pulse) valid on every cycle.
  modport master (
    output button, pause_btn, start_num,
    input  c_out, blink_hr_sig, blink_min_sig, blink_sec_sig, running, tick, mode
  );

  modport slave (
    input  button, pause_btn, start_num,
    output c_out, blink_hr_sig, blink_min_sig, blink_sec_sig, running, tick, mode
  );

endinterface

// File: rtl/clock_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level counter and a
// one-cycle pulse when the accepted level falls (press; releases are silent).
module btn_debounce #(
  parameter int DEBOUNCE = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic          sync1, sync2;
  logic          stable, stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable_d & ~stable;
      // Any sample equal to the accepted level restarts the stability run.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// Clock application sequencer: set hour/minute/second from the switches,
// then run a 24-hour time-of-day counter with pause and re-set.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int HALF_SEC = 25000000,
  parameter int DEBOUNCE = 500000
) (
  input logic         clk,
  input logic         rst,
  clock_ctrl_if.slave bus
);

  localparam int            PW         = $clog2(CLK_HZ + 1);
  localparam int            BW         = $clog2(HALF_SEC + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(HALF_SEC - 1);

  state_t            state;
  logic [4:0]        hr;
  logic [5:0]        min, sec;
  logic [PW-1:0]     presc;
  logic [BW-1:0]     blink_cnt;
  logic              phase;
  logic              tick_r;
  logic [TIME_W-1:0] c_out_r;

  logic       btn_press, pause_press;
  logic [4:0] hr_in;
  logic [5:0] ms_in;
  logic       in_set, leave, day_end;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
    .clk(clk), .rst(rst), .raw(bus.button), .press(btn_press)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_pause (
    .clk(clk), .rst(rst), .raw(bus.pause_btn), .press(pause_press)
  );

  assign hr_in   = (bus.start_num > 6'(MAX_HR)) ? 5'(MAX_HR) : bus.start_num[4:0];
  assign ms_in   = (bus.start_num > 6'(MAX_MS)) ? 6'(MAX_MS) : bus.start_num;
  assign in_set  = (state == SET_HR) || (state == SET_MIN) || (state == SET_SEC);
  // pause_btn only moves the FSM out of RUN or PAUSE.
  assign leave   = btn_press || (pause_press && (state == RUN || state == PAUSE));
  assign day_end = (to_seconds(hr, min, sec) == TIME_W'(DAY_LAST));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SET_HR;
      hr        <= '0;
      min       <= '0;
      sec       <= '0;
      presc     <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      tick_r    <= 1'b0;
      c_out_r   <= '0;
    end else begin
      tick_r  <= 1'b0;
      c_out_r <= to_seconds(hr, min, sec);

      // Every state change restarts the blink so the new field starts visible.
      if (!in_set || leave) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      case (state)
        SET_HR: begin
          hr <= hr_in;
          if (btn_press) state <= SET_MIN;
        end
        SET_MIN: begin
          min <= ms_in;
          if (btn_press) state <= SET_SEC;
        end
        SET_SEC: begin
          sec <= ms_in;
          if (btn_press) begin
            state <= RUN;
            presc <= '0;
          end
        end
        RUN: begin
          if (presc == PRESC_LAST) begin
            presc  <= '0;
            tick_r <= 1'b1;
            if (sec == 6'(MAX_MS)) begin
              sec <= '0;
              if (min == 6'(MAX_MS)) begin
                min <= '0;
                hr  <= day_end ? 5'd0 : hr + 5'd1;
              end else begin
                min <= min + 6'd1;
              end
            end else begin
              sec <= sec + 6'd1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
          if (btn_press)        state <= SET_HR;
          else if (pause_press) state <= PAUSE;
        end
        PAUSE: begin
          if (btn_press)        state <= SET_HR;
          else if (pause_press) state <= RUN;
        end
        default: state <= SET_HR;
      endcase
    end
  end

  assign bus.c_out         = c_out_r;
  assign bus.tick          = tick_r;
  assign bus.running       = (state == RUN);
  assign bus.mode          = state;
  assign bus.blink_hr_sig  = phase & (state == SET_HR);
  assign bus.blink_min_sig = phase & (state == SET_MIN);
  assign bus.blink_sec_sig = phase & (state == SET_SEC);

endmodule

// File: tb/tb_clock_ctrl.sv
// Randomized bench for clock_ctrl: a seconds-level model of the set/run/pause
// behaviour predicts c_out, tick, mode, running and the blink flags per cycle.
module tb_clock_ctrl;

  localparam int CLK_HZ   = 10;
  localparam int HALF_SEC = 4;
  localparam int DEBOUNCE = 3;
  localparam int DAY      = 86400;

  logic clk = 1'b0;
  logic rst = 1'b0;

  clock_ctrl_if bus ();

  clock_ctrl #(
    .CLK_HZ(CLK_HZ), .HALF_SEC(HALF_SEC), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [16:0] exp_q[$];

  // model: mode as number, fields, run-cycle count, cycles since state entry
  int m_state = 0, m_h = 0, m_m = 0, m_s = 0, m_k = 0, m_j = 0;
  bit pend_btn = 0, pend_pause = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_secs();
    return m_h * 3600 + m_m * 60 + m_s;
  endfunction

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Advance n clock edges, updating the model and checking all outputs.
  task automatic step(input int n);
    int  exp_c, t, exp_b;
    bit  inc, moved;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      inc   = 0;
      moved = 0;
      if (!rst) begin
        m_state = 0; m_h = 0; m_m = 0; m_s = 0; m_k = 0; m_j = 0;
        exp_q.delete();
        exp_c = 0;
      end else begin
        exp_c = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : 0;
        case (m_state)
          0: m_h = clamp(int'(bus.start_num), 23);
          1: m_m = clamp(int'(bus.start_num), 59);
          2: m_s = clamp(int'(bus.start_num), 59);
          3: begin
            m_k++;
            if (m_k % CLK_HZ == 0) begin
              t   = (m_secs() + 1) % DAY;
              m_h = t / 3600;
              m_m = (t / 60) % 60;
              m_s = t % 60;
              inc = 1;
            end
          end
          default: ;
        endcase
        if (pend_btn) begin
          moved = 1;
          case (m_state)
            0: m_state = 1;
            1: m_state = 2;
            2: begin m_state = 3; m_k = 0; end
            default: m_state = 0;
          endcase
        end else if (pend_pause && m_state == 3) begin
          moved = 1; m_state = 4;
        end else if (pend_pause && m_state == 4) begin
          moved = 1; m_state = 3;
        end
        m_j = moved ? 0 : m_j + 1;
      end
      exp_q.push_back(17'(m_secs()));
      #1;
      exp_b = (m_state <= 2 && ((m_j / HALF_SEC) % 2 == 1)) ? (1 << m_state) : 0;
      check("c_out", 32'(bus.c_out), exp_c);
      check("tick", 32'(bus.tick), 32'(inc));
      check("mode", 32'(bus.mode), m_state);
      check("running", 32'(bus.running), 32'(m_state == 3));
      check("blink", {29'd0, bus.blink_sec_sig, bus.blink_min_sig, bus.blink_hr_sig}, exp_b);
    end
  endtask

  // driver: hold the raw line(s) low long enough for one accepted press
  task automatic press(input bit b, input bit p);
    if (b) bus.button = 1'b0;
    if (p) bus.pause_btn = 1'b0;
    step(DEBOUNCE + 3);
    pend_btn   = b;
    pend_pause = p;
    step(1);
    pend_btn      = 0;
    pend_pause    = 0;
    bus.button    = 1'b1;
    bus.pause_btn = 1'b1;
    step(DEBOUNCE + 4);
  endtask

  initial begin
    int kind;
    bus.button    = 1'b1;
    bus.pause_btn = 1'b1;
    bus.start_num = 6'd0;
    rst = 1'b0;
    step(3);
    rst = 1'b1;

    // set 13:45:07 and run
    bus.start_num = 6'd13; step(2); press(1, 0);
    bus.start_num = 6'd45; press(1, 0);
    bus.start_num = 6'd7;  press(1, 0);
    check("plan_run_cout", 32'(bus.c_out), 49507);
    check("plan_running", 32'(bus.running), 1);

    // clamped set of 23:59:58, then roll over midnight
    press(1, 0);
    bus.start_num = 6'd40; step(3); press(1, 0);
    bus.start_num = 6'd63; step(3); press(1, 0);
    bus.start_num = 6'd58; press(1, 0);
    step(20);
    check("plan_wrap", 32'(bus.c_out), 0);

    // pause, hold, resume with retained prescaler
    step(3);
    press(0, 1);
    step(50);
    press(0, 1);
    step(25);

    // blink in SET_MIN and SET_SEC
    press(1, 0); press(1, 0);
    step(20);
    press(1, 0);
    step(10);

    // simultaneous presses, glitch rejection, reset mid-run
    press(1, 0);
    step(4);
    press(1, 1);
    bus.button = 1'b0; step(2); bus.button = 1'b1; step(10);
    press(1, 0); press(1, 0); press(1, 0);
    step(15);
    rst = 1'b0;
    step(2);
    check("reset_cout", 32'(bus.c_out), 0);
    check("reset_mode", 32'(bus.mode), 0);
    rst = 1'b1;
    step(3);

    // random traffic
    for (int r = 0; r < 30; r++) begin
      bus.start_num = 6'($urandom_range(0, 63));
      kind = $urandom_range(0, 4);
      case (kind)
        0, 1: press(1, 0);
        2:    press(0, 1);
        3:    press(1, 1);
        default: step($urandom_range(1, 30));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
